// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem addressing, IF/ID boundary register,
// branch redirect, stall/flush handling, out-of-range fetch guard with halt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          IMEM_WORDS    = 64,
  parameter logic [31:0] NOP_INSTR     = 32'hE1A0_0000,
  parameter bit          HALT_ON_FAULT = 1'b1,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StallF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             BranchTakenE,
  input  logic [31:0]      BranchTargetE,
  output logic [31:0]      PCF,
  input  logic [31:0]      InstrF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCD,
  output logic [31:0]      PCPlus8D,
  output logic             ValidD,
  output logic             FaultD,
  output logic             Halted,
  output logic [CNT_W-1:0] FetchCount
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

  state_t      state, stateNext;
  logic        faultF;
  logic        loadD;
  logic        faultLatch;
  logic [31:0] pcNext;
  logic        unusedTargetBits;

  assign faultF           = (PCF[31:2] >= IMEM_LIMIT);
  assign Halted           = (state == HALT);
  assign unusedTargetBits = ^BranchTargetE[1:0];

  // Entering HALT freezes the PC on the faulting address, so the fault edge wins over branches.
  always_comb begin
    stateNext  = state;
    pcNext     = PCF;
    loadD      = 1'b0;
    faultLatch = 1'b0;
    if (state == RUN) begin
      loadD      = !FlushD && !StallD;
      faultLatch = loadD && faultF;
      if (faultLatch && HALT_ON_FAULT) begin
        stateNext = HALT;
      end else if (BranchTakenE) begin
        pcNext = {BranchTargetE[31:2], 2'b00};
      end else if (!StallF) begin
        pcNext = PCF + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PCF      <= RESET_PC;
      InstrD   <= NOP_INSTR;
      PCD      <= 32'd0;
      PCPlus8D <= 32'd8;
      ValidD   <= 1'b0;
      FaultD   <= 1'b0;
    end else begin
      PCF <= pcNext;
      if (state == HALT || FlushD) begin
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
        FaultD <= 1'b0;
      end else if (!StallD) begin
        PCD      <= PCF;
        PCPlus8D <= PCF + 32'd8;
        if (faultF) begin
          InstrD <= NOP_INSTR;
          ValidD <= 1'b0;
          FaultD <= 1'b1;
        end else begin
          InstrD <= InstrF;
          ValidD <= 1'b1;
          FaultD <= 1'b0;
        end
      end
    end
  end

  // Counts only real instructions entering D; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FetchCount <= '0;
    end else if (loadD && !faultF && (FetchCount != '1)) begin
      FetchCount <= FetchCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instr;
    logic [31:0] pcD;
    logic [31:0] pc8;
    logic        valid;
    logic        fault;
    logic        halted;
    logic [31:0] count;
    bit          chkPc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD, BranchTakenE;
  logic [31:0] BranchTargetE;
  logic [31:0] PCF, InstrF, InstrD, PCD, PCPlus8D;
  logic        ValidD, FaultD, Halted;
  logic [31:0] FetchCount;

  exp_t q[$];
  int   passCount  = 0;
  int   checkCount = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .PCF(PCF), .InstrF(InstrF),
    .InstrD(InstrD), .PCD(PCD), .PCPlus8D(PCPlus8D),
    .ValidD(ValidD), .FaultD(FaultD), .Halted(Halted),
    .FetchCount(FetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem word i holds 0xA000_0000 | i; out-of-range reads return a marker word.
  always_comb begin
    if (PCF[31:2] < 30'd64) InstrF = 32'hA000_0000 | {26'd0, PCF[7:2]};
    else                    InstrF = 32'hDEAD_BEEF;
  end

  function automatic exp_t mk(input logic [31:0] pcf, instr, pcD, pc8,
                              input logic valid, fault, halted,
                              input logic [31:0] count, input bit chkPc);
    exp_t e;
    e.pcf = pcf; e.instr = instr; e.pcD = pcD; e.pc8 = pc8;
    e.valid = valid; e.fault = fault; e.halted = halted;
    e.count = count; e.chkPc = chkPc;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
    checkCount++;
    if (act !== want) $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    else passCount++;
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("PCF", PCF, e.pcf);
    cmp("InstrD", InstrD, e.instr);
    cmp("ValidD", {31'd0, ValidD}, {31'd0, e.valid});
    cmp("FaultD", {31'd0, FaultD}, {31'd0, e.fault});
    cmp("Halted", {31'd0, Halted}, {31'd0, e.halted});
    cmp("FetchCount", FetchCount, e.count);
    if (e.chkPc) begin
      cmp("PCD", PCD, e.pcD);
      cmp("PCPlus8D", PCPlus8D, e.pc8);
    end
  endtask

  task automatic applyStimulus(input logic sF, sD, fD, br, input logic [31:0] tgt, input exp_t e);
    @(negedge clk);
    StallF = sF; StallD = sD; FlushD = fD; BranchTakenE = br; BranchTargetE = tgt;
    q.push_back(e);
  endtask

  // Asserts reset away from any edge, checks the async reset values, then releases.
  task automatic resetCheck();
    @(posedge clk);
    #3;
    reset = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; BranchTargetE = 0;
    #1;
    checkOutput(mk(32'h0, NOP, 32'h0, 32'h8, 0, 0, 0, 0, 1));
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) checkOutput(q.pop_front());
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    reset = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; BranchTargetE = 0;
    resetCheck();

    // sequential fetch
    applyStimulus(0, 0, 0, 0, 0, mk(32'h04, 32'hA000_0000, 32'h00, 32'h08, 1, 0, 0, 1, 1));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h08, 32'hA000_0001, 32'h04, 32'h0C, 1, 0, 0, 2, 1));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h0C, 32'hA000_0002, 32'h08, 32'h10, 1, 0, 0, 3, 1));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h10, 32'hA000_0003, 32'h0C, 32'h14, 1, 0, 0, 4, 1));

    // full stall at PCF=0x10, then release
    applyStimulus(1, 1, 0, 0, 0, mk(32'h10, 32'hA000_0003, 32'h0C, 32'h14, 1, 0, 0, 4, 1));
    applyStimulus(1, 1, 0, 0, 0, mk(32'h10, 32'hA000_0003, 32'h0C, 32'h14, 1, 0, 0, 4, 1));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h14, 32'hA000_0004, 32'h10, 32'h18, 1, 0, 0, 5, 1));

    // branch redirect with flush, branch beats StallF, target aligned
    applyStimulus(1, 0, 1, 1, 32'h53, mk(32'h50, NOP, 32'h0, 32'h0, 0, 0, 0, 5, 0));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h54, 32'hA000_0014, 32'h50, 32'h58, 1, 0, 0, 6, 1));

    // flush beats StallD, no count
    applyStimulus(0, 1, 1, 0, 0, mk(32'h58, NOP, 32'h0, 32'h0, 0, 0, 0, 6, 0));
    // StallF alone: D reloads the held PCF word
    applyStimulus(1, 0, 0, 0, 0, mk(32'h58, 32'hA000_0016, 32'h58, 32'h60, 1, 0, 0, 7, 1));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h5C, 32'hA000_0016, 32'h58, 32'h60, 1, 0, 0, 8, 1));

    // run off the end of imem into the fault/halt
    applyStimulus(0, 0, 1, 1, 32'hF8, mk(32'hF8, NOP, 32'h0, 32'h0, 0, 0, 0, 8, 0));
    applyStimulus(0, 0, 0, 0, 0, mk(32'hFC, 32'hA000_003E, 32'hF8, 32'h100, 1, 0, 0, 9, 1));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h100, 32'hA000_003F, 32'hFC, 32'h104, 1, 0, 0, 10, 1));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h100, NOP, 32'h100, 32'h108, 0, 1, 1, 10, 1));
    applyStimulus(0, 0, 1, 1, 32'h0, mk(32'h100, NOP, 32'h0, 32'h0, 0, 0, 1, 10, 0));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h100, NOP, 32'h0, 32'h0, 0, 0, 1, 10, 0));

    // reset while halted, restart at RESET_PC
    resetCheck();
    applyStimulus(0, 0, 0, 0, 0, mk(32'h04, 32'hA000_0000, 32'h00, 32'h08, 1, 0, 0, 1, 1));
    applyStimulus(0, 0, 0, 0, 0, mk(32'h08, 32'hA000_0001, 32'h04, 32'h0C, 1, 0, 0, 2, 1));

    // reset mid-run
    resetCheck();
    applyStimulus(0, 0, 0, 0, 0, mk(32'h04, 32'hA000_0000, 32'h00, 32'h08, 1, 0, 0, 1, 1));

    @(posedge clk);
    #3;
    checkCount++;
    if (q.size() != 0) $display("[TB] FAIL scoreboard drain: got %0d entries left, expected 0", q.size());
    else passCount++;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
